vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Programmable VGA raster timing generator: the source of the `hcount`/`vcount`/`hsync`/`vsync`/`hblnk`/`vblnk` bundle that every draw stage consumes and re-registers downstream. It sits at the head of the video pipeline, clocked by the pixel clock. It produces fully registered, mutually aligned timing signals for a parameterised mode, default 800x600@60 Hz with a 40 MHz `pclk`. It also provides a one-cycle frame-start strobe for game logic that updates once per frame.

## Interface
Parameters:
- `H_VISIBLE`, 800, active pixels per line
- `H_FRONT`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, hsync width (pixels)
- `H_BACK`, 88, horizontal back porch (pixels)
- `V_VISIBLE`, 600, active lines per frame
- `V_FRONT`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vsync width (lines)
- `V_BACK`, 23, vertical back porch (lines)
- `H_SYNC_POL`, 1, active level of hsync
- `V_SYNC_POL`, 1, active level of vsync

Ports:
- `pclk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0)
- `en`  in  1  advance enable; 0 freezes the raster
- `hcount_out`  out  11  current pixel column, 0..H_TOTAL-1
- `vcount_out`  out  11  current line, 0..V_TOTAL-1
- `hsync_out`  out  1  horizontal sync, polarity per `H_SYNC_POL`
- `vsync_out`  out  1  vertical sync, polarity per `V_SYNC_POL`
- `hblnk_out`  out  1  horizontal blanking, active high
- `vblnk_out`  out  1  vertical blanking, active high
- `frame_start`  out  1  one-cycle strobe when raster enters (0,0)

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (default 1056).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (default 628).
  - Both totals must be ≤ 2048; this is an elaboration-time check.
- Horizontal counter:
  - Increments by 1 on each edge with `en`=1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Increments only on the horizontal wrap edge.
  - Wraps from V_TOTAL-1 to 0 when both counters are at their maximum.
- Output decode, applied to the *same* counter value presented on `hcount_out`/`vcount_out`:
  - `hblnk_out` = 1 iff hcount ≥ H_VISIBLE.
  - `vblnk_out` = 1 iff vcount ≥ V_VISIBLE.
  - `hsync_out` is active iff H_VISIBLE+H_FRONT ≤ hcount < H_VISIBLE+H_FRONT+H_SYNC (default 840..967).
  - `vsync_out` is active iff V_VISIBLE+V_FRONT ≤ vcount < V_VISIBLE+V_FRONT+V_SYNC (default 601..604).
- `frame_start` = 1 for exactly the cycle in which the outputs show (0,0) as a result of a frame wrap. It is not asserted on the reset state itself.
- `en`=0:
  - All counters and timing outputs hold their values.
  - `frame_start` is forced to 0.
  - A frozen (0,0) does not re-strobe.

## Timing
- Reset values (while `rst`=0, asynchronously):
  - `hcount_out`=0, `vcount_out`=0.
  - `hblnk_out`=0, `vblnk_out`=0, `frame_start`=0.
  - `hsync_out`=~H_SYNC_POL, `vsync_out`=~V_SYNC_POL.
- All outputs are registered in the same flop stage. There is zero skew between counts and decoded flags: the next-state counts and decodes are computed combinationally and registered together.
- First edge after `rst` deasserts with `en`=1 → outputs show (1,0).
- Latency from `en` change to output effect: 1 cycle.
- Simultaneous H wrap and V wrap: both counters go to 0 on the same edge, and `frame_start` rises on that edge.
- Reset asserted mid-frame: outputs return to reset values immediately. There is no partial-frame completion.

## Structure
- Package `vga_timing_pkg` holds:
  - default mode constants for 800x600@60;
  - the count width constant (11);
  - a function computing totals and sync windows, shared with draw stages that need `H_VISIBLE`/`V_VISIBLE`.
- Sub-module `vga_axis_counter` (parameters: TOTAL, VISIBLE, SYNC_START, SYNC_LEN, SYNC_POL; inputs: `step`; outputs: next count, blank, sync, wrap), instantiated twice:
  - horizontal instance: `step`=`en`;
  - vertical instance: `step`=`en` & horizontal wrap.
- Top level registers the combined outputs and `frame_start`.

## Test plan
- Reset hold then release, `en`=1 → during reset all outputs at reset values; first post-release edge gives hcount=1, vcount=0, hblnk=0.
- Run line 0 → hblnk rises exactly at hcount=800; hsync active for hcount 840..967 (128 cycles); at 1055→0, vcount 0→1.
- Run full frame → vblnk=1 from vcount=600; vsync active on lines 601..604; at (1055,627) the next edge gives (0,0) with `frame_start`=1 for one cycle; period 1056×628=663168 cycles between strobes.
- Drop `en` for 10 cycles at hcount=839 → all outputs frozen; hsync asserts only on the first enabled edge after `en` returns; no `frame_start` while frozen at (0,0).
- Assert `rst` at (500,300) for 3 cycles → outputs jump to reset values asynchronously; restart matches the first scenario.
- Small mode (H 8/2/2/2, V 4/1/1/1, SYNC_POL=0) → hsync low at hcount 10..11, vsync low on line 5, H_TOTAL=14, V_TOTAL=7 wrap correct.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA raster timing package: default 800x600@60 mode, count width and a
// helper that derives line/frame totals and sync windows from porch widths.
package vga_timing_pkg;

  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 40;
  localparam int DEF_H_SYNC    = 128;
  localparam int DEF_H_BACK    = 88;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 1;
  localparam int DEF_V_SYNC    = 4;
  localparam int DEF_V_BACK    = 23;

  typedef struct packed {
    int total;
    int sync_start;
    int sync_len;
  } axis_cfg_t;

  function automatic axis_cfg_t axis_cfg(
    input int visible,
    input int front,
    input int sync,
    input int back
  );
    axis_cfg_t c;
    c.total      = visible + front + sync + back;
    c.sync_start = visible + front;
    c.sync_len   = sync;
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: next-count, wrap and blank/sync decode of the next count.
// Ports: count (current registered value), step -> count_nxt, blank, sync, wrap.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 1056,
  parameter int VISIBLE    = 800,
  parameter int SYNC_START = 840,
  parameter int SYNC_LEN   = 128,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic [CNT_W-1:0] count,
  input  logic             step,
  output logic [CNT_W-1:0] count_nxt,
  output logic             blank,
  output logic             sync,
  output logic             wrap
);

  // One bit wider so a sync window ending at 2048 still compares cleanly.
  localparam logic [CNT_W:0] LAST = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] VIS  = (CNT_W+1)'(VISIBLE);
  localparam logic [CNT_W:0] SS   = (CNT_W+1)'(SYNC_START);
  localparam logic [CNT_W:0] SE   = (CNT_W+1)'(SYNC_START + SYNC_LEN);

  logic [CNT_W:0] cur_w;
  logic [CNT_W:0] nxt_w;
  logic           in_sync;

  assign cur_w = {1'b0, count};
  assign nxt_w = {1'b0, count_nxt};
  assign wrap  = step && (cur_w == LAST);

  always_comb begin
    count_nxt = count;
    if (step) begin
      count_nxt = wrap ? '0 : count + 1'b1;
    end
  end

  assign in_sync = (nxt_w >= SS) && (nxt_w < SE);
  assign blank   = nxt_w >= VIS;
  assign sync    = in_sync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator; counts, sync, blank and frame_start
// all leave the same register stage. Ports: pclk, rst (async low), en.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic             frame_start
);

  localparam axis_cfg_t H_CFG =
    axis_cfg(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam axis_cfg_t V_CFG =
    axis_cfg(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_CFG.total > MAX_TOTAL) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_CFG.total > MAX_TOTAL) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 2048");
  end

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_blank;
  logic             v_blank;
  logic             h_sync;
  logic             v_sync;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(
    .TOTAL      (H_CFG.total),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_CFG.sync_start),
    .SYNC_LEN   (H_CFG.sync_len),
    .SYNC_POL   (H_SYNC_POL)
  ) u_h (
    .count     (hcount_out),
    .step      (en),
    .count_nxt (h_nxt),
    .blank     (h_blank),
    .sync      (h_sync),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL      (V_CFG.total),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_CFG.sync_start),
    .SYNC_LEN   (V_CFG.sync_len),
    .SYNC_POL   (V_SYNC_POL)
  ) u_v (
    .count     (vcount_out),
    .step      (en & h_wrap),
    .count_nxt (v_nxt),
    .blank     (v_blank),
    .sync      (v_sync),
    .wrap      (v_wrap)
  );

  // v_wrap already implies en, so a frozen (0,0) never re-strobes.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= ~H_SYNC_POL;
      vsync_out   <= ~V_SYNC_POL;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= h_nxt;
      vcount_out  <= v_nxt;
      hsync_out   <= h_sync;
      vsync_out   <= v_sync;
      hblnk_out   <= h_blank;
      vblnk_out   <= v_blank;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode line checks from a vector table,
// small mode (14x7, low-active sync) against a queued reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } vo_t;

  typedef struct {
    int  k;
    vo_t e;
  } dvec_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic        en_d;
  logic        en_s;
  logic [10:0] d_h, d_v, s_h, s_v;
  logic        d_hs, d_vs, d_hb, d_vb, d_fs;
  logic        s_hs, s_vs, s_hb, s_vb, s_fs;

  always #5 pclk = ~pclk;

  vga_timing_gen dut_d (
    .pclk        (pclk),
    .rst         (rst),
    .en          (en_d),
    .hcount_out  (d_h),
    .vcount_out  (d_v),
    .hsync_out   (d_hs),
    .vsync_out   (d_vs),
    .hblnk_out   (d_hb),
    .vblnk_out   (d_vb),
    .frame_start (d_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0)
  ) dut_s (
    .pclk        (pclk),
    .rst         (rst),
    .en          (en_s),
    .hcount_out  (s_h),
    .vcount_out  (s_v),
    .hsync_out   (s_hs),
    .vsync_out   (s_vs),
    .hblnk_out   (s_hb),
    .vblnk_out   (s_vb),
    .frame_start (s_fs)
  );

  int    total  = 0;
  int    passed = 0;
  int    kd     = 0;
  int    mh     = 0;
  int    mv     = 0;
  bit    mfs    = 1'b0;
  vo_t   q[$];
  dvec_t tbl[10];

  function automatic vo_t mk(int h, int v, bit hs, bit vs,
                             bit hb, bit vb, bit fs);
    vo_t r;
    r.h = 11'(h); r.v = 11'(v);
    r.hs = hs; r.vs = vs; r.hb = hb; r.vb = vb; r.fs = fs;
    return r;
  endfunction

  function automatic vo_t got_d();
    return {d_h, d_v, d_hs, d_vs, d_hb, d_vb, d_fs};
  endfunction

  function automatic vo_t got_s();
    return {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs};
  endfunction

  // Small mode: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), sync active low.
  function automatic vo_t s_model_out();
    return mk(mh, mv, !(mh >= 10 && mh < 12), !(mv == 5),
              mh >= 8, mv >= 4, mfs);
  endfunction

  task automatic chk(input string nm, input vo_t g, input vo_t e);
    total++;
    if (g !== e)
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
               nm, g.h, g.v, g.hs, g.vs, g.hb, g.vb, g.fs,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs);
    else
      passed++;
  endtask

  task automatic chk_int(input string nm, input int g, input int e);
    total++;
    if (g !== e) $display("FAIL %s: got %0d, want %0d", nm, g, e);
    else passed++;
  endtask

  task automatic d_cycle(input bit e);
    @(negedge pclk);
    en_d = e;
    @(posedge pclk);
    #1;
    if (e) kd++;
  endtask

  task automatic sb_cycle(input bit e);
    vo_t ex;
    @(negedge pclk);
    en_s = e;
    if (e) begin
      mfs = (mh == 13 && mv == 6);
      if (mh == 13) begin
        mh = 0;
        mv = (mv == 6) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end else begin
      mfs = 1'b0;
    end
    q.push_back(s_model_out());
    @(posedge pclk);
    #1;
    ex = q.pop_front();
    chk("small_sb", got_s(), ex);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst  = 1'b0;
    en_d = 1'b1;
    en_s = 1'b0;

    tbl[0] = '{1,    mk(1,    0, 0, 0, 0, 0, 0)};
    tbl[1] = '{799,  mk(799,  0, 0, 0, 0, 0, 0)};
    tbl[2] = '{800,  mk(800,  0, 0, 0, 1, 0, 0)};
    tbl[3] = '{839,  mk(839,  0, 0, 0, 1, 0, 0)};
    tbl[4] = '{840,  mk(840,  0, 1, 0, 1, 0, 0)};
    tbl[5] = '{967,  mk(967,  0, 1, 0, 1, 0, 0)};
    tbl[6] = '{968,  mk(968,  0, 0, 0, 1, 0, 0)};
    tbl[7] = '{1055, mk(1055, 0, 0, 0, 1, 0, 0)};
    tbl[8] = '{1056, mk(0,    1, 0, 0, 0, 0, 0)};
    tbl[9] = '{1057, mk(1,    1, 0, 0, 0, 0, 0)};

    repeat (3) @(posedge pclk);
    #1;
    chk("d_reset", got_d(), mk(0, 0, 0, 0, 0, 0, 0));
    chk("s_reset", got_s(), mk(0, 0, 1, 1, 0, 0, 0));

    @(negedge pclk);
    rst  = 1'b1;
    en_d = 1'b1;
    @(posedge pclk);
    #1;
    kd = 1;

    for (int i = 0; i < 10; i++) begin
      while (kd < tbl[i].k) d_cycle(1'b1);
      chk($sformatf("d_vec%0d", i), got_d(), tbl[i].e);
    end

    while (kd < 1056 + 839) d_cycle(1'b1);
    chk("d_pre_freeze", got_d(), mk(839, 1, 0, 0, 1, 0, 0));
    repeat (10) begin
      d_cycle(1'b0);
      chk("d_frozen", got_d(), mk(839, 1, 0, 0, 1, 0, 0));
    end
    d_cycle(1'b1);
    chk("d_resume", got_d(), mk(840, 1, 1, 0, 1, 0, 0));

    chk("s_idle", got_s(), mk(0, 0, 1, 1, 0, 0, 0));

    repeat (196) sb_cycle(1'b1);
    repeat (5) sb_cycle(1'b0);
    repeat (200) sb_cycle($urandom_range(0, 3) != 0);

    for (int i = 0; i < 300 && !(mh == 13 && mv == 6); i++)
      sb_cycle(1'b1);
    sb_cycle(1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      sb_cycle(1'b1);
      n++;
      if (s_fs) break;
    end
    chk_int("s_frame_period", n, 98);

    for (int i = 0; i < 300 && !(mh == 5 && mv == 3); i++)
      sb_cycle(1'b1);
    @(negedge pclk);
    rst = 1'b0;
    #1;
    chk("s_async_rst", got_s(), mk(0, 0, 1, 1, 0, 0, 0));
    chk("d_async_rst", got_d(), mk(0, 0, 0, 0, 0, 0, 0));
    mh  = 0;
    mv  = 0;
    mfs = 1'b0;
    repeat (3) begin
      @(posedge pclk);
      #1;
      chk("s_rst_hold", got_s(), mk(0, 0, 1, 1, 0, 0, 0));
    end
    @(negedge pclk);
    rst  = 1'b1;
    en_s = 1'b1;
    @(posedge pclk);
    #1;
    chk("s_restart", got_s(), mk(1, 0, 1, 1, 0, 0, 0));
    mh = 1;
    repeat (20) sb_cycle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
